gpio_arbiter: RTL and testbench
===============================

GPIO_ARBITER -- requirements
Module: gpio_arbiter

Interface
REQ-001 Parameter HOLD_CYCLES, default 2: cycles the pins are driven per write; legal range 1..15.
REQ-002 Parameter TURN_CYCLES, default 1: bus-turnaround cycles with outEn low before a read samples; legal range 1..7.
REQ-003 Parameter SYNC_STAGES, default 2: input synchronizer depth; legal range 2..3.
REQ-004 clk  input  1: single clock; all logic on its rising edge.
REQ-005 RST  input  1: reset, synchronous, active-high.
REQ-006 req  input  2: per-port transaction request, bit i = port i.
REQ-007 we  input  2: per-port direction, 1 = write, 0 = read; valid while req high.
REQ-008 wdata0  input  8: port 0 write data.
REQ-009 wdata1  input  8: port 1 write data.
REQ-010 ack  output  2: one-cycle completion pulse per port.
REQ-011 rdata  output  8: read result, valid in the cycle ack is high for a read.
REQ-012 busy  output  1: high whenever the FSM is not in IDLE.
REQ-013 outEn  output  1: drive enable to the GPIO pad block.
REQ-014 oData  output  8: drive data to the GPIO pad block.
REQ-015 pinIn  input  8: asynchronous pad readback of ioPin.

Function
REQ-016 FSM states IDLE, DRIVE, TURN and SAMPLE; all outputs registered.
REQ-017 In IDLE with any req high at cycle t, grant one port, latch its we and wdata, and toggle the round-robin pointer to the other port.
REQ-018 Grant on simultaneous requests: port named by the pointer; single request: that port, regardless of pointer.
REQ-019 Write: DRIVE for cycles t+1..t+HOLD_CYCLES with outEn=1 and oData=latched wdata; ack pulses in the last DRIVE cycle; IDLE follows.
REQ-020 After a write, outEn and oData hold their values through IDLE until the next read or reset.
REQ-021 Read with outEn=1: TURN for TURN_CYCLES cycles with outEn=0, then SAMPLE.
REQ-022 Read with outEn=0: go directly from IDLE to SAMPLE.
REQ-023 SAMPLE lasts SYNC_STAGES+1 cycles; in the last cycle, rdata = synchronizer output and ack pulses; IDLE follows; outEn stays 0.
REQ-024 rdata holds its last value between reads.
REQ-025 Synchronizer on pinIn is free-running, SYNC_STAGES flops deep.
REQ-026 Requester holds req, we and wdata stable until ack, and drops req the cycle after ack.
REQ-027 A req dropped mid-transaction does not abort it; ack is still issued.
REQ-028 req is ignored outside IDLE; no back-to-back grant without an IDLE cycle between transactions.
REQ-029 Phase counters are 4 bits wide and reload on every state entry.

Reset
REQ-030 RST high at any clock edge, including mid-transaction, forces on the next cycle: IDLE, outEn=0, oData=0, ack=0, rdata=0, busy=0, pointer=0, synchronizer flops=0, counters=0.
REQ-031 Transactions interrupted by reset are not acked.

Structure
REQ-032 Package gpio_arb_pkg holds the state enum, the port-count constant (2) and the parameter-range limits.
REQ-033 Sub-module gpio_sync is the parameterized N-stage 8-bit synchronizer, instantiated once.

Verification
REQ-034 Port 0 write 8'hA5 at t, defaults -> outEn=1, oData=A5 from t+1; ack[0] at t+2; outEn still 1 at t+5.
REQ-035 Port 1 read after that write, pinIn=8'h3C -> outEn=0 from t+1 (TURN); SAMPLE t+2..t+4; ack[1] and rdata=3C at t+4.
REQ-036 Read with outEn already 0 and pinIn=8'h81 -> ack at t+3 with rdata=81; pinIn changing to 8'h00 at t+2 still returns 81.
REQ-037 Both ports requesting writes continuously after reset -> grants alternate 0,1,0,1; each ack followed by one IDLE cycle.
REQ-038 RST asserted at t+1 of a write -> t+2 shows IDLE, outEn=0, oData=0 and no ack; a subsequent request is granted to port 0 on a tie.

Source files
------------

// File: rtl/gpio_arb_pkg.sv
// Shared types and constants for the two-port GPIO arbiter.
package gpio_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int CNT_W     = 4;

  localparam int HOLD_MIN = 1;
  localparam int HOLD_MAX = 15;
  localparam int TURN_MIN = 1;
  localparam int TURN_MAX = 7;
  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    TURN   = 2'd2,
    SAMPLE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/gpio_sync.sv
// Free-running N-stage synchronizer for the asynchronous pad readback bus.
module gpio_sync #(
  parameter int STAGES = 2,
  parameter int W      = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] stage_q [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_arbiter.sv
// Round-robin arbiter sharing one GPIO pad bank between two requesters,
// with write hold, bus turnaround before reads and synchronized readback.
module gpio_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int TURN_CYCLES = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 RST,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] we,
  input  logic [7:0]           wdata0,
  input  logic [7:0]           wdata1,
  output logic [NUM_PORTS-1:0] ack,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 outEn,
  output logic [7:0]           oData,
  input  logic [7:0]           pinIn,
  output arb_state_e           dbg_state_o
);

  // Handshake: a requester raises req[i] with we[i]/wdata stable and holds
  // them until ack[i] pulses; req is only sampled in IDLE, so a request
  // withdrawn mid-transaction still completes and is acked.

  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LOAD = CNT_W'(SYNC_STAGES);

  arb_state_e             state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   gnt_q;
  logic                   ptr_q;
  logic [NUM_PORTS-1:0]   ack_q;
  logic [7:0]             rdata_q;
  logic                   busy_q;
  logic                   out_en_q;
  logic [7:0]             o_data_q;
  logic                   grant_d;
  logic [7:0]             sync_out;

  gpio_sync #(
    .STAGES (SYNC_STAGES),
    .W      (8)
  ) u_sync (
    .clk (clk),
    .rst (RST),
    .d_i (pinIn),
    .q_o (sync_out)
  );

  always_comb begin
    grant_d = 1'b0;
    if (req == 2'b11) grant_d = ptr_q;
    else if (req[1])  grant_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      gnt_q    <= 1'b0;
      ptr_q    <= 1'b0;
      ack_q    <= '0;
      rdata_q  <= '0;
      busy_q   <= 1'b0;
      out_en_q <= 1'b0;
      o_data_q <= '0;
    end else begin
      ack_q <= '0;
      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q  <= grant_d;
            ptr_q  <= ~grant_d;
            busy_q <= 1'b1;
            if (we[grant_d]) begin
              state_q  <= DRIVE;
              cnt_q    <= HOLD_LOAD;
              out_en_q <= 1'b1;
              o_data_q <= grant_d ? wdata1 : wdata0;
              if (HOLD_CYCLES == 1) ack_q[grant_d] <= 1'b1;
            end else if (out_en_q) begin
              state_q  <= TURN;
              cnt_q    <= TURN_LOAD;
              out_en_q <= 1'b0;
            end else begin
              state_q <= SAMPLE;
              cnt_q   <= SAMPLE_LOAD;
            end
          end
        end
        DRIVE: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) ack_q[gnt_q] <= 1'b1;
          end
        end
        TURN: begin
          if (cnt_q == '0) begin
            state_q <= SAMPLE;
            cnt_q   <= SAMPLE_LOAD;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        SAMPLE: begin
          if (cnt_q == '0) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            // Capture lands in the final SAMPLE cycle, together with ack.
            if (cnt_q == CNT_W'(1)) begin
              ack_q[gnt_q] <= 1'b1;
              rdata_q      <= sync_out;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign outEn       = out_en_q;
  assign oData       = o_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_gpio_arbiter.sv
// Self-checking bench for gpio_arbiter: directed scenarios plus randomized
// transactions compared against a transaction-level reference model.
module tb_gpio_arbiter;
  import gpio_arb_pkg::*;

  localparam int P_HOLD = 2;
  localparam int P_TURN = 1;
  localparam int P_SYNC = 2;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [7:0] wdata0 = '0;
  logic [7:0] wdata1 = '0;
  logic [7:0] pinIn = '0;
  logic [1:0] ack;
  logic [7:0] rdata;
  logic       busy;
  logic       outEn;
  logic [7:0] oData;
  arb_state_e dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: arbitration pointer and the values the pads/readback hold.
  int         m_ptr = 0;
  bit         m_out_en = 1'b0;
  logic [7:0] m_o_data = '0;
  logic [7:0] m_rdata = '0;
  logic [1:0] exp_q[$];

  gpio_arbiter #(
    .HOLD_CYCLES (P_HOLD),
    .TURN_CYCLES (P_TURN),
    .SYNC_STAGES (P_SYNC)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .req         (req),
    .we          (we),
    .wdata0      (wdata0),
    .wdata1      (wdata1),
    .ack         (ack),
    .rdata       (rdata),
    .busy        (busy),
    .outEn       (outEn),
    .oData       (oData),
    .pinIn       (pinIn),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr    = 0;
    m_out_en = 1'b0;
    m_o_data = '0;
    m_rdata  = '0;
    exp_q.delete();
  endtask

  task automatic apply_reset(input int n);
    RST = 1'b1;
    req = '0;
    repeat (n) @(negedge clk);
    check_eq("rst_ack",   32'(ack),       32'd0);
    check_eq("rst_busy",  32'(busy),      32'd0);
    check_eq("rst_outen", 32'(outEn),     32'd0);
    check_eq("rst_odata", 32'(oData),     32'd0);
    check_eq("rst_rdata", 32'(rdata),     32'd0);
    check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
    RST = 1'b0;
    model_reset();
  endtask

  task automatic idle_check(input string tag);
    check_eq({tag, "_busy"},  32'(busy),      32'd0);
    check_eq({tag, "_ack"},   32'(ack),       32'd0);
    check_eq({tag, "_state"}, 32'(dbg_state), 32'(IDLE));
    check_eq({tag, "_outen"}, 32'(outEn),     32'(m_out_en));
    check_eq({tag, "_rdata"}, 32'(rdata),     32'(m_rdata));
    if (m_out_en) check_eq({tag, "_odata"}, 32'(oData), 32'(m_o_data));
  endtask

  task automatic idle_cycles(input int n);
    req = '0;
    repeat (n) begin
      @(negedge clk);
      idle_check("idle");
    end
  endtask

  // Called during an IDLE cycle before its capturing edge; returns at the
  // negedge of the IDLE cycle that follows the ack.
  task automatic run_txn(input logic [1:0] r, input logic [1:0] w,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] pin, input bit drop_early,
                         input bit chain, input bit pin_chg,
                         input logic [7:0] pin2, output int g);
    int         dur;
    int         n_turn;
    bit         is_wr;
    logic [7:0] old_rd;
    g      = (r == 2'b11) ? m_ptr : (r[1] ? 1 : 0);
    m_ptr  = 1 - g;
    is_wr  = w[g];
    n_turn = (!is_wr && m_out_en) ? P_TURN : 0;
    dur    = is_wr ? P_HOLD : n_turn + P_SYNC + 1;
    exp_q.push_back(2'(1 << g));
    old_rd = m_rdata;
    if (is_wr) begin
      m_out_en = 1'b1;
      m_o_data = (g == 1) ? d1 : d0;
    end else begin
      m_out_en = 1'b0;
      m_rdata  = pin;
    end
    req = r; we = w; wdata0 = d0; wdata1 = d1; pinIn = pin;
    for (int k = 1; k <= dur; k++) begin
      @(negedge clk);
      check_eq("txn_busy",  32'(busy),  32'd1);
      check_eq("txn_outen", 32'(outEn), 32'(m_out_en));
      if (is_wr) begin
        check_eq("txn_state", 32'(dbg_state), 32'(DRIVE));
        check_eq("txn_odata", 32'(oData), 32'(m_o_data));
      end else begin
        check_eq("txn_state", 32'(dbg_state), (k <= n_turn) ? 32'(TURN) : 32'(SAMPLE));
      end
      if (k == dur) begin
        check_eq("txn_ack",   32'(ack),   32'(exp_q.pop_front()));
        check_eq("txn_rdata", 32'(rdata), 32'(m_rdata));
      end else begin
        check_eq("txn_noack", 32'(ack),   32'd0);
        check_eq("txn_rhold", 32'(rdata), 32'(old_rd));
      end
      if (k == 1 && drop_early) req = '0;
      if (k == 1 && pin_chg) begin
        @(posedge clk);
        #1;
        pinIn = pin2;
      end
    end
    @(posedge clk);
    #1;
    if (!chain) req = '0;
    @(negedge clk);
    idle_check("post");
  endtask

  initial begin
    int g;
    int gap;
    logic [1:0] r;
    logic [1:0] w;

    apply_reset(3);

    // Both ports writing continuously: grants alternate 0,1,0,1.
    for (int i = 0; i < 4; i++) begin
      run_txn(2'b11, 2'b11, 8'($urandom), 8'($urandom), 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, g);
    end
    idle_cycles(1);

    apply_reset(2);
    // Port 0 write A5, then outEn must still be high well after the ack.
    run_txn(2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g);
    idle_cycles(2);
    // Port 1 read after the write: one turnaround cycle, then sample 3C.
    run_txn(2'b10, 2'b00, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, g);
    idle_cycles(1);
    // Read with outEn low: direct to SAMPLE; late pin change must not leak in.
    run_txn(2'b01, 2'b00, 8'h00, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1, 8'h00, g);
    idle_cycles(1);

    // Reset landing in the middle of a write.
    req = 2'b01; we = 2'b01; wdata0 = 8'h5A;
    @(negedge clk);
    check_eq("rstmid_drive", 32'(outEn), 32'd1);
    RST = 1'b1;
    @(negedge clk);
    check_eq("rstmid_state", 32'(dbg_state), 32'(IDLE));
    check_eq("rstmid_outen", 32'(outEn),     32'd0);
    check_eq("rstmid_odata", 32'(oData),     32'd0);
    check_eq("rstmid_ack",   32'(ack),       32'd0);
    check_eq("rstmid_busy",  32'(busy),      32'd0);
    RST = 1'b0;
    req = '0;
    model_reset();
    run_txn(2'b11, 2'b11, 8'h11, 8'h22, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, g);
    idle_cycles(1);

    // Randomized traffic.
    for (int i = 0; i < 80; i++) begin
      r   = 2'($urandom_range(1, 3));
      w   = 2'($urandom_range(0, 3));
      gap = $urandom_range(0, 2);
      run_txn(r, w, 8'($urandom), 8'($urandom), 8'($urandom),
              1'($urandom_range(0, 1)), (gap == 0), 1'b0, 8'h00, g);
      if (gap > 1) idle_cycles(gap - 1);
    end
    idle_cycles(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
